// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if
// Groups the plaintext/ciphertext handshake and the round-key lookup of
// aes_round_ctrl into one bundle.
//   in_valid / in_ready / plaintext      : plaintext accept handshake
//   rk_idx / round_key                   : combinational key-store lookup
//   busy                                 : rounds in progress
//   out_valid / out_ready / ciphertext   : ciphertext delivery handshake
//   abort                                : only when AES_CTRL_ABORT_EN is defined
// 128-bit blocks use FIPS-197 ordering: FIPS bit 0 (MSB of byte 0) sits in
// bit [127], and byte n = 4*column + row occupies bits [127-8n -: 8].
// Modports: slave = controller side, master = producer/consumer/key-store side.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
`ifdef AES_CTRL_ABORT_EN
  logic         abort;

  modport slave (
    input  in_valid, plaintext, round_key, out_ready, abort,
    output in_ready, rk_idx, busy, out_valid, ciphertext
  );
  modport master (
    output in_valid, plaintext, round_key, out_ready, abort,
    input  in_ready, rk_idx, busy, out_valid, ciphertext
  );
`else
  modport slave (
    input  in_valid, plaintext, round_key, out_ready,
    output in_ready, rk_idx, busy, out_valid, ciphertext
  );
  modport master (
    output in_valid, plaintext, round_key, out_ready,
    input  in_ready, rk_idx, busy, out_valid, ciphertext
  );
`endif
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Iterative AES-128 encryption controller. Accepts one plaintext block,
// applies the initial AddRoundKey, then runs one shared round datapath for
// 10 rounds (MixColumns bypassed in round 10) and holds the ciphertext in
// DONE until the consumer takes it. Round keys are fetched from an external
// combinational key store addressed by rk_idx.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset, priority over everything
//   bus    : aes_round_ctrl_if.slave (handshakes, key lookup, status)
// Optional feature: define AES_CTRL_ABORT_EN to add bus.abort, which returns
// the block to IDLE from ROUND or DONE and discards the block in flight.
module aes_round_ctrl (
  input  logic            clk,
  input  logic            reset,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_r;
  state_e       state_nxt_s;
  logic [3:0]   round_cnt_r;
  logic [127:0] state_reg_r;
  logic         abort_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;
  logic [127:0] round_out_s;

  // GF(2^8) multiply by x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  // GF(2^8) general multiply, shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

`ifdef AES_CTRL_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // One shared round: single MixColumns instance, bypassed in the final round
  always_comb begin
    sr_s        = shift_rows(sub_bytes(state_reg_r));
    mc_s        = mix_columns(sr_s);
    round_out_s = ((round_cnt_r == 4'd10) ? sr_s : mc_s) ^ bus.round_key;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; counts 11..15 are illegal and fall back to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nxt_s = ROUND;
        else              state_nxt_s = IDLE;
      end
      ROUND: begin
        if (abort_s)                    state_nxt_s = IDLE;
        else if (round_cnt_r > 4'd10)   state_nxt_s = IDLE;
        else if (round_cnt_r == 4'd10)  state_nxt_s = DONE;
        else                            state_nxt_s = ROUND;
      end
      DONE: begin
        if (abort_s)            state_nxt_s = IDLE;
        else if (bus.out_ready) state_nxt_s = IDLE;
        else                    state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs decoded from registered state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = 4'd0;
    case (state_r)
      IDLE:  bus.in_ready = 1'b1;
      ROUND: begin
        bus.busy   = 1'b1;
        bus.rk_idx = round_cnt_r;
      end
      DONE:  bus.out_valid = 1'b1;
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Block state and round counter; the state register doubles as ciphertext
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg_r <= 128'h0;
      round_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg_r <= bus.plaintext ^ bus.round_key;
            round_cnt_r <= 4'd1;
          end else begin
            round_cnt_r <= 4'd0;
          end
        end
        ROUND: begin
          if (abort_s || (round_cnt_r > 4'd10)) begin
            state_reg_r <= 128'h0;
            round_cnt_r <= 4'd0;
          end else begin
            state_reg_r <= round_out_s;
            round_cnt_r <= (round_cnt_r == 4'd10) ? 4'd0 : round_cnt_r + 4'd1;
          end
        end
        DONE: begin
          if (abort_s) begin
            state_reg_r <= 128'h0;
          end else begin
            state_reg_r <= state_reg_r;
          end
          round_cnt_r <= 4'd0;
        end
        default: begin
          state_reg_r <= 128'h0;
          round_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign bus.ciphertext = state_reg_r;

endmodule
